// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-RAM responder: access sizes, FSM states and
// the lane mask helper.
package dmem_responder_pkg;

    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;
    localparam logic [2:0] SZ_D = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DATA
    } state_t;

    // Right-aligned bit mask covering the access width.
    function automatic logic [63:0] size_mask(input logic [2:0] sz);
        logic [63:0] m;
        case (sz)
            SZ_B:    m = 64'h0000_0000_0000_00FF;
            SZ_H:    m = 64'h0000_0000_0000_FFFF;
            SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store-unit data-RAM request port: strobe, request fields and the
// data/ready/error response.
interface dmem_responder_if;
    logic        ram_cen_i;
    logic        ram_wen_i;
    logic [63:0] ram_addr_i;
    logic [2:0]  ram_size_i;
    logic [63:0] ram_wdata_i;
    logic [63:0] ram_data_o;
    logic        ram_ready_o;
    logic        ram_err_o;

    modport master (
        output ram_cen_i, ram_wen_i, ram_addr_i, ram_size_i, ram_wdata_i,
        input  ram_data_o, ram_ready_o, ram_err_o
    );

    modport slave (
        input  ram_cen_i, ram_wen_i, ram_addr_i, ram_size_i, ram_wdata_i,
        output ram_data_o, ram_ready_o, ram_err_o
    );
endinterface

// File: rtl/dmem_responder_lane_align.sv
// Combinational lane steering between right-aligned request data and the
// 64-bit SRAM word, plus the size/offset legality check.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [2:0]  i_off,
    input  logic [2:0]  i_size,
    input  logic [63:0] i_wdata,
    input  logic [63:0] i_rdata,
    output logic [63:0] o_wmask,
    output logic [63:0] o_wdata,
    output logic [63:0] o_rdata,
    output logic        o_align_err
);

    logic [63:0] w_lane_mask;
    logic [5:0]  w_shamt;
    logic [3:0]  w_bytes;

    assign w_lane_mask = size_mask(i_size);
    assign w_shamt     = {i_off, 3'b000};
    assign w_bytes     = 4'd1 << i_size[1:0];

    assign o_wmask = w_lane_mask << w_shamt;
    assign o_wdata = i_wdata << w_shamt;
    assign o_rdata = (i_rdata >> w_shamt) & w_lane_mask;

    // An access may not spill past the end of its 64-bit word.
    assign o_align_err = i_size[2] | (({1'b0, i_off} + w_bytes) > 4'd8);

endmodule

// File: rtl/dmem_responder.sv
// Data-RAM responder: one request at a time, LATENCY wait cycles, then a
// lane-aligned SRAM access and a one-cycle ready (with error) pulse.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter int          ADDR_W    = 16,
    parameter int          LATENCY   = 0
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   ram,
    output logic              sram_en_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [63:0]       sram_wmask_o,
    output logic [63:0]       sram_wdata_o,
    input  logic [63:0]       sram_rdata_i
);

    localparam logic [63:0] LIMIT = 64'd8 << ADDR_W;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_wen;
    logic [63:0] r_addr;
    logic [2:0]  r_size;
    logic [63:0] r_wdata;
    logic [63:0] r_data;
    logic        r_ready;
    logic        r_err;

    logic        w_accept;
    logic [63:0] w_offs;
    logic        w_oob;
    logic        w_align_err;
    logic        w_err;
    logic [63:0] w_rdata;

    dmem_lane_align u_align (
        .i_off       (r_addr[2:0]),
        .i_size      (r_size),
        .i_wdata     (r_wdata),
        .i_rdata     (sram_rdata_i),
        .o_wmask     (sram_wmask_o),
        .o_wdata     (sram_wdata_o),
        .o_rdata     (w_rdata),
        .o_align_err (w_align_err)
    );

    // Latched fields are stable for the whole request, so the error derived
    // from them is identical to one computed at latch time.
    assign w_accept = (r_state == ST_IDLE) & ram.ram_cen_i;
    assign w_offs   = r_addr - BASE_ADDR;
    assign w_oob    = (r_addr < BASE_ADDR) | (w_offs >= LIMIT);
    assign w_err    = w_align_err | w_oob;

    assign sram_en_o   = (r_state == ST_ACCESS) & ~w_err;
    assign sram_we_o   = (r_state == ST_ACCESS) & r_wen & ~w_err;
    assign sram_addr_o = w_offs[ADDR_W+2:3];

    assign ram.ram_data_o  = r_data;
    assign ram.ram_ready_o = r_ready;
    assign ram.ram_err_o   = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (ram.ram_cen_i) begin
                    if (LATENCY > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 4'(LATENCY - 1);
                    end else begin
                        w_state_nxt = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_ACCESS;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            ST_ACCESS: w_state_nxt = ST_DATA;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_wen   <= ram.ram_wen_i;
                r_addr  <= ram.ram_addr_i;
                r_size  <= ram.ram_size_i;
                r_wdata <= ram.ram_wdata_i;
            end
            r_ready <= (r_state == ST_DATA);
            r_err   <= (r_state == ST_DATA) & w_err;
            if (r_state == ST_DATA)
                r_data <= (r_wen | w_err) ? 64'd0 : w_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a LATENCY=0 and a LATENCY=3 instance,
// each backed by a small behavioural SRAM.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int AW = 8;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if if0 ();
    dmem_responder_if if3 ();

    logic          en0, we0, en3, we3;
    logic [AW-1:0] addr0, addr3;
    logic [63:0]   wmask0, wdata0, rdata0, wmask3, wdata3, rdata3;
    logic [63:0]   mem0 [2**AW];
    logic [63:0]   mem3 [2**AW];

    dmem_responder #(.ADDR_W(AW), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .ram(if0),
        .sram_en_o(en0), .sram_we_o(we0), .sram_addr_o(addr0),
        .sram_wmask_o(wmask0), .sram_wdata_o(wdata0), .sram_rdata_i(rdata0)
    );

    dmem_responder #(.ADDR_W(AW), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .ram(if3),
        .sram_en_o(en3), .sram_we_o(we3), .sram_addr_o(addr3),
        .sram_wmask_o(wmask3), .sram_wdata_o(wdata3), .sram_rdata_i(rdata3)
    );

    always @(posedge clk) begin
        if (en0) begin
            if (we0) mem0[addr0] <= (mem0[addr0] & ~wmask0) | (wdata0 & wmask0);
            rdata0 <= mem0[addr0];
        end
        if (en3) begin
            if (we3) mem3[addr3] <= (mem3[addr3] & ~wmask3) | (wdata3 & wmask3);
            rdata3 <= mem3[addr3];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    exp_t        q0[$];
    exp_t        q3[$];
    exp_t        e0, e3;
    int          en_cnt0 = 0, en_cnt3 = 0;

    always @(negedge clk) begin
        if (en0) en_cnt0++;
        if (en3) en_cnt3++;
        if (if0.ram_err_o && !if0.ram_ready_o) chk("d0_err_without_ready", 64'd1, 64'd0);
        if (if3.ram_err_o && !if3.ram_ready_o) chk("d3_err_without_ready", 64'd1, 64'd0);
        if (if0.ram_ready_o) begin
            if (q0.size() == 0) chk("d0_unexpected_ready", 64'd1, 64'd0);
            else begin
                e0 = q0.pop_front();
                chk("d0_data",  if0.ram_data_o, e0.data);
                chk("d0_err",   64'(if0.ram_err_o), 64'(e0.err));
                chk("d0_cycle", 64'(cyc), 64'(e0.cyc));
            end
        end
        if (if3.ram_ready_o) begin
            if (q3.size() == 0) chk("d3_unexpected_ready", 64'd1, 64'd0);
            else begin
                e3 = q3.pop_front();
                chk("d3_data",  if3.ram_data_o, e3.data);
                chk("d3_err",   64'(if3.ram_err_o), 64'(e3.err));
                chk("d3_cycle", 64'(cyc), 64'(e3.cyc));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one strobe cycle (the current one) and returns one cycle later
    // with the request fields scrambled, so late sampling shows up.
    task automatic req(input int d, input bit push, input bit wen, input logic [63:0] a,
                       input logic [2:0] sz, input logic [63:0] wd,
                       input logic [63:0] ed, input bit ee);
        exp_t x;
        x.data = ed;
        x.err  = ee;
        x.cyc  = cyc + 3 + ((d == 0) ? 0 : 3);
        if (d == 0) begin
            if0.ram_cen_i = 1'b1; if0.ram_wen_i = wen; if0.ram_addr_i = a;
            if0.ram_size_i = sz; if0.ram_wdata_i = wd;
            if (push) q0.push_back(x);
        end else begin
            if3.ram_cen_i = 1'b1; if3.ram_wen_i = wen; if3.ram_addr_i = a;
            if3.ram_size_i = sz; if3.ram_wdata_i = wd;
            if (push) q3.push_back(x);
        end
        @(posedge clk);
        #1;
        if (d == 0) begin
            if0.ram_cen_i = 1'b0; if0.ram_wen_i = ~wen; if0.ram_addr_i = {$urandom, $urandom};
            if0.ram_size_i = 3'($urandom); if0.ram_wdata_i = {$urandom, $urandom};
        end else begin
            if3.ram_cen_i = 1'b0; if3.ram_wen_i = ~wen; if3.ram_addr_i = {$urandom, $urandom};
            if3.ram_size_i = 3'($urandom); if3.ram_wdata_i = {$urandom, $urandom};
        end
    endtask

    initial begin
        int c;
        int n;
        for (int i = 0; i < 2**AW; i++) begin
            mem0[i] = '0;
            mem3[i] = '0;
        end
        rdata0 = '0;
        rdata3 = '0;
        if0.ram_cen_i = 0; if0.ram_wen_i = 0; if0.ram_addr_i = '0; if0.ram_size_i = '0; if0.ram_wdata_i = '0;
        if3.ram_cen_i = 0; if3.ram_wen_i = 0; if3.ram_addr_i = '0; if3.ram_size_i = '0; if3.ram_wdata_i = '0;
        step(3);
        rst = 1'b0;

        chk("rst_ready0", 64'(if0.ram_ready_o), 64'd0);
        chk("rst_err0",   64'(if0.ram_err_o),   64'd0);
        chk("rst_data0",  if0.ram_data_o,       64'd0);
        chk("rst_en0",    64'(en0),             64'd0);
        chk("rst_we0",    64'(we0),             64'd0);
        chk("rst_ready3", 64'(if3.ram_ready_o), 64'd0);
        chk("rst_en3",    64'(en3),             64'd0);
        step(1);

        // Doubleword store and read-back, with the access-cycle SRAM controls.
        req(0, 1, 1, 64'h8000_0010, SZ_D, 64'h1122_3344_5566_7788, 64'd0, 0);
        chk("t1_en",    64'(en0),   64'd1);
        chk("t1_we",    64'(we0),   64'd1);
        chk("t1_addr",  64'(addr0), 64'd2);
        chk("t1_wmask", wmask0,     '1);
        chk("t1_wdata", wdata0,     64'h1122_3344_5566_7788);
        step(3);
        req(0, 1, 0, 64'h8000_0010, SZ_D, 64'd0, 64'h1122_3344_5566_7788, 0);
        chk("t1_ld_we", 64'(we0), 64'd0);
        step(3);

        // Sub-word store and loads of every size.
        req(0, 1, 1, 64'h8000_0013, SZ_B, 64'h0000_0000_0000_00AB, 64'd0, 0);
        chk("t2_wmask", wmask0, 64'h0000_0000_FF00_0000);
        chk("t2_wdata", wdata0, 64'h0000_0000_AB00_0000);
        step(3);
        req(0, 1, 0, 64'h8000_0013, SZ_B, 64'd0, 64'h0000_0000_0000_00AB, 0); step(3);
        req(0, 1, 0, 64'h8000_0012, SZ_H, 64'd0, 64'h0000_0000_0000_AB66, 0); step(3);
        req(0, 1, 0, 64'h8000_0014, SZ_W, 64'd0, 64'h0000_0000_1122_3344, 0); step(3);
        req(0, 1, 0, 64'h8000_0010, SZ_D, 64'd0, 64'h1122_3344_AB66_7788, 0); step(3);

        // Rejected requests never reach the SRAM.
        n = en_cnt0;
        req(0, 1, 1, 64'h8000_0016, SZ_W, 64'hFFFF_FFFF, 64'd0, 1); step(3);
        req(0, 1, 1, 64'h8000_0017, SZ_H, 64'hFFFF,      64'd0, 1); step(3);
        req(0, 1, 0, 64'h7FFF_FFF8, SZ_D, 64'd0,         64'd0, 1); step(3);
        req(0, 1, 0, 64'h8000_0800, SZ_D, 64'd0,         64'd0, 1); step(3);
        req(0, 1, 0, 64'h8000_0010, 3'b100, 64'd0,       64'd0, 1); step(3);
        chk("t3_no_sram_access", 64'(en_cnt0), 64'(n));
        req(0, 1, 0, 64'h8000_0010, SZ_D, 64'd0, 64'h1122_3344_AB66_7788, 0); step(3);
        req(0, 1, 1, 64'h8000_07F8, SZ_D, 64'hA5A5_0000_5A5A_FFFF, 64'd0, 0); step(3);
        req(0, 1, 0, 64'h8000_07F8, SZ_D, 64'd0, 64'hA5A5_0000_5A5A_FFFF, 0); step(3);

        // LATENCY=3: wait timing, ignored strobe while busy, back-to-back.
        c = cyc;
        req(3, 1, 1, 64'h8000_0020, SZ_D, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 0);
        step(2);
        chk("t5_en_early", 64'(en3), 64'd0);
        step(1);
        chk("t5_st_cycle", 64'(cyc),   64'(c + 4));
        chk("t5_st_en",    64'(en3),   64'd1);
        chk("t5_st_addr",  64'(addr3), 64'd4);
        step(3);
        c = cyc;
        req(3, 1, 0, 64'h8000_0020, SZ_D, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 0);
        step(1);
        req(3, 0, 1, 64'h8000_0028, SZ_D, 64'h0123_4567_89AB_CDEF, 64'd0, 0);
        step(1);
        chk("t5_ld_en",   64'(en3),   64'd1);
        chk("t5_ld_we",   64'(we3),   64'd0);
        chk("t5_ld_addr", 64'(addr3), 64'd4);
        step(2);
        chk("t5_ready_cycle", 64'(cyc), 64'(c + 6));
        req(3, 1, 0, 64'h8000_0024, SZ_W, 64'd0, 64'h0000_0000_DEAD_BEEF, 0);
        step(6);

        // Reset during the wait phase aborts the store entirely.
        req(3, 0, 1, 64'h8000_0020, SZ_D, 64'd0, 64'd0, 0);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n = en_cnt3;
        chk("t6_data_cleared", if3.ram_data_o,       64'd0);
        chk("t6_ready_low",    64'(if3.ram_ready_o), 64'd0);
        step(8);
        chk("t6_no_sram_access", 64'(en_cnt3), 64'(n));
        req(3, 1, 0, 64'h8000_0020, SZ_D, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 0);
        step(7);

        chk("pending0", 64'(q0.size()), 64'd0);
        chk("pending3", 64'(q3.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
